// File: rtl/deadlock_idx0_monitor.sv
// ---------------------------------------------------------------------------
// deadlock_idx0_monitor
//
// Purpose:
//   Deadlock detector for one kernel hierarchy level (index 0), used on the
//   simulation side. It watches three groups of flags from the kernel's
//   sub-instances:
//     - AXI-stream blocking flags
//     - per-instance idle flags
//     - per-instance block flags
//   It raises `block` once the kernel has been stalled for THRESHOLD
//   consecutive clock edges. The kernel-level wrapper owns all reporting.
//
// Ports:
//   clock           : sole clock; all state updates on its rising edge.
//   reset           : asynchronous, active-low reset.
//   axis_block_sigs : [AXIS_W] bit k = 1 -> stream port k is blocked.
//   inst_idle_sigs  : [IDLE_W] bit i = 1 -> instance i is idle.
//                     Unused slots are tied to 0.
//   inst_block_sigs : [BLK_W]  bit j = 1 -> instance j is internally blocked.
//                     Unused slots are tied to 0.
//   block           : registered deadlock indication (not sticky).
// ---------------------------------------------------------------------------
module deadlock_idx0_monitor #(
  parameter int AXIS_W    = 2,
  parameter int IDLE_W    = 2,
  parameter int BLK_W     = 1,
  parameter int THRESHOLD = 16,  // legal range 1 .. 2**CNT_W-1
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AXIS_W-1:0] axis_block_sigs,
  input  logic [IDLE_W-1:0] inst_idle_sigs,
  input  logic [BLK_W-1:0]  inst_block_sigs,
  output logic              block
);

  localparam logic [CNT_W-1:0] THRESHOLD_C = CNT_W'(THRESHOLD);

  // -------------------------------------------------------------------------
  // Flag reductions, built as explicit OR/AND chains.
  // -------------------------------------------------------------------------
  logic [AXIS_W:0] axis_chain;
  logic [BLK_W:0]  inst_blk_chain;
  logic [IDLE_W:0] idle_chain;

  assign axis_chain[0]     = 1'b0;
  assign inst_blk_chain[0] = 1'b0;
  assign idle_chain[0]     = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < AXIS_W; gi++) begin : g_axis_or
      assign axis_chain[gi+1] = axis_chain[gi] | axis_block_sigs[gi];
    end
    for (gi = 0; gi < BLK_W; gi++) begin : g_inst_blk_or
      assign inst_blk_chain[gi+1] = inst_blk_chain[gi] | inst_block_sigs[gi];
    end
    for (gi = 0; gi < IDLE_W; gi++) begin : g_idle_and
      assign idle_chain[gi+1] = idle_chain[gi] & inst_idle_sigs[gi];
    end
  endgenerate

  logic any_axis;
  logic any_inst;
  logic all_idle;
  logic inputs_unknown;
  logic stall_now;

  assign any_axis = axis_chain[AXIS_W];
  assign any_inst = inst_blk_chain[BLK_W];
  assign all_idle = idle_chain[IDLE_W];

  // An undefined input must never produce a false deadlock report. Any X/Z
  // therefore forces the stall term low, which also clears the counter.
  assign inputs_unknown = $isunknown({axis_block_sigs, inst_idle_sigs, inst_block_sigs});

  // A fully idle kernel is never deadlocked, even with a stream flag raised.
  assign stall_now = ~inputs_unknown & (any_axis | any_inst) & ~all_idle;

  // -------------------------------------------------------------------------
  // Stall counter.
  // The counter saturates at THRESHOLD, so it cannot wrap back into a
  // non-blocked value during a long stall.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             block_reg;
  logic             block_next;

  always_comb begin
    cnt_next = '0;
    if (stall_now) begin
      if (cnt_reg < THRESHOLD_C) begin
        cnt_next = cnt_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg;
      end
    end
  end

  // `block` is derived from the next count, not the current one. This way it
  // rises on exactly the THRESHOLD-th stalled edge, and falls on the first
  // clean edge.
  assign block_next = (cnt_next == THRESHOLD_C);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      block_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      block_reg <= block_next;
    end
  end

  assign block = block_reg;

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
module tb_deadlock_idx0_monitor;

  localparam int AXIS_W    = 2;
  localparam int IDLE_W    = 2;
  localparam int BLK_W     = 1;
  localparam int THRESHOLD = 16;
  localparam int CNT_W     = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [AXIS_W-1:0] axis_block_sigs = '0;
  logic [IDLE_W-1:0] inst_idle_sigs  = '0;
  logic [BLK_W-1:0]  inst_block_sigs = '0;
  logic              block;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  //   stall_run      : number of consecutive stalled edges since the last
  //                    clean edge or reset.
  //   expected block : stall_run >= THRESHOLD
  int stall_run = 0;

  deadlock_idx0_monitor #(
    .AXIS_W(AXIS_W), .IDLE_W(IDLE_W), .BLK_W(BLK_W),
    .THRESHOLD(THRESHOLD), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .block(block)
  );

  always #5 clock = ~clock;

  function automatic bit model_stall();
    bit any_src;
    bit idle_all;
    any_src  = (axis_block_sigs != 0) || (inst_block_sigs != 0);
    idle_all = (inst_idle_sigs == {IDLE_W{1'b1}});
    return any_src && !idle_all;
  endfunction

  function automatic logic model_block();
    return (stall_run >= THRESHOLD) ? 1'b1 : 1'b0;
  endfunction

  // Advance one rising edge, update the model, and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clock);
    if (!reset)             stall_run = 0;
    else if (model_stall()) stall_run = stall_run + 1;
    else                    stall_run = 0;
    #1;
  endtask

  task automatic set_inputs(input logic [AXIS_W-1:0] a,
                            input logic [IDLE_W-1:0] i,
                            input logic [BLK_W-1:0]  b);
    axis_block_sigs = a;
    inst_idle_sigs  = i;
    inst_block_sigs = b;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_inputs('0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (block !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d block=%b expected=0", c, block);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (block !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d block=%b expected=0", c, block);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_stream_stall();
    logic exp;
    set_inputs(2'b01, 2'b00, 1'b0);
    for (int e = 1; e <= THRESHOLD + 5; e++) begin
      tick();
      exp = (e >= THRESHOLD) ? 1'b1 : 1'b0;
      checks++;
      if (block !== exp || block !== model_block()) begin
        failures++;
        $display("FAIL stream_stall edge=%0d block=%b expected=%b", e, block, exp);
      end
    end
    $display("test_stream_stall done");
  endtask

  task automatic test_stall_broken();
    logic exp;
    set_inputs('0, 2'b00, 1'b0);
    tick();
    checks++;
    if (block !== 1'b0) begin
      failures++;
      $display("FAIL stall_broken_drop block=%b expected=0", block);
    end
    set_inputs(2'b10, 2'b00, 1'b0);
    for (int e = 1; e <= THRESHOLD; e++) begin
      tick();
      exp = (e == THRESHOLD) ? 1'b1 : 1'b0;
      checks++;
      if (block !== exp) begin
        failures++;
        $display("FAIL stall_rearm edge=%0d block=%b expected=%b", e, block, exp);
      end
    end
    $display("test_stall_broken done");
  endtask

  task automatic test_short_stall();
    set_inputs('0, 2'b00, 1'b0);
    tick();
    for (int r = 0; r < 5; r++) begin
      for (int e = 0; e < THRESHOLD; e++) begin
        inst_block_sigs = (e < THRESHOLD - 1) ? 1'b1 : 1'b0;
        tick();
        checks++;
        if (block !== 1'b0) begin
          failures++;
          $display("FAIL short_stall rep=%0d edge=%0d block=%b expected=0", r, e, block);
        end
      end
    end
    $display("test_short_stall done");
  endtask

  task automatic test_idle_override();
    logic exp;
    set_inputs(2'b11, 2'b11, 1'b0);
    for (int e = 0; e < 40; e++) begin
      tick();
      checks++;
      if (block !== 1'b0) begin
        failures++;
        $display("FAIL idle_override edge=%0d block=%b expected=0", e, block);
      end
    end
    inst_idle_sigs = 2'b10;
    for (int e = 1; e <= THRESHOLD; e++) begin
      tick();
      exp = (e == THRESHOLD) ? 1'b1 : 1'b0;
      checks++;
      if (block !== exp) begin
        failures++;
        $display("FAIL idle_released edge=%0d block=%b expected=%b", e, block, exp);
      end
    end
    $display("test_idle_override done");
  endtask

  task automatic test_async_reset();
    logic exp;
    // The previous test leaves `block` high; check that first.
    checks++;
    if (block !== 1'b1) begin
      failures++;
      $display("FAIL async_pre block=%b expected=1", block);
    end
    #2;
    reset = 1'b0;
    stall_run = 0;
    #1;
    checks++;
    if (block !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_immediate block=%b expected=0", block);
    end
    tick();
    checks++;
    if (block !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_held block=%b expected=0", block);
    end
    reset = 1'b1;
    for (int e = 1; e <= THRESHOLD; e++) begin
      tick();
      exp = (e == THRESHOLD) ? 1'b1 : 1'b0;
      checks++;
      if (block !== exp) begin
        failures++;
        $display("FAIL async_restart edge=%0d block=%b expected=%b", e, block, exp);
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int n_mism;
    n_mism = 0;
    for (int c = 0; c < 1500; c++) begin
      // Mostly hold the inputs, so that long stalls actually occur.
      if ($urandom_range(0, 19) == 0) begin
        axis_block_sigs = AXIS_W'($urandom_range(0, 3));
        inst_block_sigs = BLK_W'($urandom_range(0, 1));
        inst_idle_sigs  = ($urandom_range(0, 3) == 0) ? 2'b11
                          : IDLE_W'($urandom_range(0, 2));
      end
      tick();
      checks++;
      if (block !== model_block()) begin
        failures++;
        n_mism++;
        if (n_mism <= 10)
          $display("FAIL random cycle=%0d run=%0d block=%b expected=%b",
                   c, stall_run, block, model_block());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_stream_stall();
    test_stall_broken();
    test_short_stall();
    test_idle_override();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
